// File: rtl/locked_adder_scheduler.sv
// -----------------------------------------------------------------------------
// locked_adder_scheduler
//
// Shares one key-locked (XOR/XNOR-encrypted) ripple-carry adder netlist
// between two requesters. A 32-bit unlock key is shifted in serially, MSB
// first, and presented on keyinput_o. Add requests are arbitrated
// round-robin. The winner's operands are driven onto the adder and held for
// SETTLE_CYCLES cycles so the combinational carry chain can settle. The sum
// is then captured and returned with a one-cycle ack.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   key_start_i             pulse: begin (or restart) a serial key load
//   key_sdi_i, key_sv_i     serial key bit (MSB first) and its valid strobe
//   key_ready_o             key fully loaded, adder usable
//   req0_i, a0_i, b0_i      requester 0: request (held until ack) + operands
//   req1_i, a1_i, b1_i      requester 1: request (held until ack) + operands
//   ack0_o, ack1_o          one-cycle completion pulse per requester
//   rsp_data_o              DATA_W+1 result, valid with ack
//   add1_o, add2_o          operands driven to the locked adder
//   keyinput_o              key bus driven to the locked adder
//   result_i                locked adder output (DATA_W+1)
//   busy_o                  high in any state other than IDLE
//   key_err_o               (only with SCHED_KEY_LOCK_EN) ignored re-key pulse
//
// Build option
//   SCHED_KEY_LOCK_EN : once a key is loaded, further key_start_i pulses are
//                       ignored until reset. Each ignored pulse seen in IDLE
//                       raises key_err_o for one cycle.
// -----------------------------------------------------------------------------
module locked_adder_scheduler #(
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned KEY_W         = 32,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              key_start_i,
   input  logic              key_sdi_i,
   input  logic              key_sv_i,
   output logic              key_ready_o,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic [DATA_W-1:0] a0_i,
   input  logic [DATA_W-1:0] b0_i,
   input  logic [DATA_W-1:0] a1_i,
   input  logic [DATA_W-1:0] b1_i,
   output logic              ack0_o,
   output logic              ack1_o,
   output logic [DATA_W:0]   rsp_data_o,
   output logic [DATA_W-1:0] add1_o,
   output logic [DATA_W-1:0] add2_o,
   output logic [KEY_W-1:0]  keyinput_o,
   input  logic [DATA_W:0]   result_i,
   output logic              busy_o
`ifdef SCHED_KEY_LOCK_EN
   ,
   output logic              key_err_o
`endif
);

   localparam int unsigned CNT_W   = (KEY_W > 2) ? $clog2(KEY_W) : 1;
   localparam int unsigned SET_MAX = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
   localparam int unsigned SET_W   = (SET_MAX > 1) ? $clog2(SET_MAX) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(KEY_W - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_MAX - 1);

   localparam logic [2:0] S_NOKEY  = 3'd0;
   localparam logic [2:0] S_KLOAD  = 3'd1;
   localparam logic [2:0] S_IDLE   = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_SETTLE = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   // State and datapath registers
   logic [2:0]        r_state;
   logic [KEY_W-2:0]  r_shift;     // only KEY_W-1 bits: the last bit goes straight to the key
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [SET_W-1:0]  r_set_cnt;
   logic [KEY_W-1:0]  r_key;
   logic              r_key_ready;
   logic              r_rr_ptr;    // 0: favour req0 on contention, 1: favour req1
   logic              r_grant;     // requester owning the current transaction
   logic [DATA_W-1:0] r_add1;
   logic [DATA_W-1:0] r_add2;
   logic [DATA_W:0]   r_rsp;
   logic              r_ack0;
   logic              r_ack1;
   logic              r_busy;
`ifdef SCHED_KEY_LOCK_EN
   logic              r_key_err;
   logic              w_key_err_nxt;
`endif

   // Next-state values
   logic [2:0]        w_state_nxt;
   logic [KEY_W-2:0]  w_shift_nxt;
   logic [CNT_W-1:0]  w_bit_cnt_nxt;
   logic [SET_W-1:0]  w_set_cnt_nxt;
   logic [KEY_W-1:0]  w_key_nxt;
   logic              w_key_ready_nxt;
   logic              w_rr_ptr_nxt;
   logic              w_grant_nxt;
   logic [DATA_W-1:0] w_add1_nxt;
   logic [DATA_W-1:0] w_add2_nxt;
   logic [DATA_W:0]   w_rsp_nxt;
   logic              w_ack0_nxt;
   logic              w_ack1_nxt;
   logic              w_busy_nxt;

   logic              w_any_req;
   logic              w_arb_pick;
   logic              w_rekey;

   // Round-robin pick: on contention follow the pointer, otherwise the lone requester
   assign w_any_req  = req0_i | req1_i;
   assign w_arb_pick = (req0_i & req1_i) ? r_rr_ptr : req1_i;

   // Whether a key_start_i seen in IDLE is honoured
`ifdef SCHED_KEY_LOCK_EN
   assign w_rekey = 1'b0;
`else
   assign w_rekey = key_start_i;
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_set_cnt_nxt   = r_set_cnt;
      w_key_nxt       = r_key;
      w_key_ready_nxt = r_key_ready;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_grant_nxt     = r_grant;
      w_add1_nxt      = r_add1;
      w_add2_nxt      = r_add2;
      w_rsp_nxt       = r_rsp;
      w_ack0_nxt      = 1'b0;
      w_ack1_nxt      = 1'b0;
`ifdef SCHED_KEY_LOCK_EN
      w_key_err_nxt   = 1'b0;
`endif

      case (r_state)
         S_NOKEY: begin
            if (key_start_i) begin
               w_state_nxt   = S_KLOAD;
               w_bit_cnt_nxt = '0;
            end
         end

         S_KLOAD: begin
            if (key_start_i) begin
               // Restart: bits already shifted are discarded by the count reset
               w_bit_cnt_nxt = '0;
            end else if (key_sv_i) begin
               if (r_bit_cnt == BIT_LAST) begin
                  // Whole key lands on the bus in one edge
                  w_key_nxt       = {r_shift, key_sdi_i};
                  w_key_ready_nxt = 1'b1;
                  w_bit_cnt_nxt   = '0;
                  w_state_nxt     = S_IDLE;
               end else begin
                  w_shift_nxt   = {r_shift[KEY_W-3:0], key_sdi_i};
                  w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               end
            end
         end

         S_IDLE: begin
`ifdef SCHED_KEY_LOCK_EN
            w_key_err_nxt = key_start_i;
`endif
            if (w_rekey) begin
               w_state_nxt     = S_KLOAD;
               w_key_ready_nxt = 1'b0;
               w_bit_cnt_nxt   = '0;
            end else if (w_any_req) begin
               w_grant_nxt  = w_arb_pick;
               w_rr_ptr_nxt = ~w_arb_pick;
               w_state_nxt  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            w_add1_nxt    = r_grant ? a1_i : a0_i;
            w_add2_nxt    = r_grant ? b1_i : b0_i;
            w_set_cnt_nxt = '0;
            w_state_nxt   = S_SETTLE;
         end

         S_SETTLE: begin
            if (r_set_cnt == SET_LAST) begin
               w_rsp_nxt   = result_i;
               w_state_nxt = S_RESP;
            end else begin
               w_set_cnt_nxt = r_set_cnt + SET_W'(1);
            end
         end

         S_RESP: begin
            w_ack0_nxt  = ~r_grant;
            w_ack1_nxt  = r_grant;
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_NOKEY;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_NOKEY;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_set_cnt   <= '0;
         r_key       <= '0;
         r_key_ready <= 1'b0;
         r_rr_ptr    <= 1'b0;
         r_grant     <= 1'b0;
         r_add1      <= '0;
         r_add2      <= '0;
         r_rsp       <= '0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_busy      <= 1'b0;
`ifdef SCHED_KEY_LOCK_EN
         r_key_err   <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_set_cnt   <= w_set_cnt_nxt;
         r_key       <= w_key_nxt;
         r_key_ready <= w_key_ready_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant     <= w_grant_nxt;
         r_add1      <= w_add1_nxt;
         r_add2      <= w_add2_nxt;
         r_rsp       <= w_rsp_nxt;
         r_ack0      <= w_ack0_nxt;
         r_ack1      <= w_ack1_nxt;
         r_busy      <= w_busy_nxt;
`ifdef SCHED_KEY_LOCK_EN
         r_key_err   <= w_key_err_nxt;
`endif
      end
   end

   assign key_ready_o = r_key_ready;
   assign keyinput_o  = r_key;
   assign add1_o      = r_add1;
   assign add2_o      = r_add2;
   assign rsp_data_o  = r_rsp;
   assign ack0_o      = r_ack0;
   assign ack1_o      = r_ack1;
   assign busy_o      = r_busy;
`ifdef SCHED_KEY_LOCK_EN
   assign key_err_o   = r_key_err;
`endif

endmodule

// File: tb/tb_locked_adder_scheduler.sv
// -----------------------------------------------------------------------------
// tb_locked_adder_scheduler
//
// Directed bench for locked_adder_scheduler. The locked adder netlist is
// stood in for by a plain behavioural adder. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_locked_adder_scheduler;

   logic        clk;
   logic        rst;
   logic        key_start;
   logic        key_sdi;
   logic        key_sv;
   logic        key_ready;
   logic        req0;
   logic        req1;
   logic [15:0] a0, b0, a1, b1;
   logic        ack0;
   logic        ack1;
   logic [16:0] rsp_data;
   logic [15:0] add1;
   logic [15:0] add2;
   logic [31:0] keyinput;
   logic [16:0] result;
   logic        busy;
`ifdef SCHED_KEY_LOCK_EN
   logic        key_err;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   locked_adder_scheduler #(
      .DATA_W(16), .KEY_W(32), .SETTLE_CYCLES(2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .key_start_i (key_start),
      .key_sdi_i   (key_sdi),
      .key_sv_i    (key_sv),
      .key_ready_o (key_ready),
      .req0_i      (req0),
      .req1_i      (req1),
      .a0_i        (a0),
      .b0_i        (b0),
      .a1_i        (a1),
      .b1_i        (b1),
      .ack0_o      (ack0),
      .ack1_o      (ack1),
      .rsp_data_o  (rsp_data),
      .add1_o      (add1),
      .add2_o      (add2),
      .keyinput_o  (keyinput),
      .result_i    (result),
`ifdef SCHED_KEY_LOCK_EN
      .key_err_o   (key_err),
`endif
      .busy_o      (busy)
   );

   // Behavioural stand-in for the unlocked adder netlist
   assign result = {1'b0, add1} + {1'b0, add2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Shift a key in MSB first; optional idle gaps. Reports any ack seen and
   // checks the key bus still holds old_key just before the final bit.
   task automatic load_bits(input logic [31:0] key, input bit gaps,
                            input logic [31:0] old_key, output bit saw_ack);
      saw_ack = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (gaps && (i % 5 == 0)) begin
            key_sv = 1'b0;
            tick();
            if (ack0 || ack1) saw_ack = 1'b1;
         end
         if (i == 0) chk("key_hold_during_load", keyinput, old_key);
         key_sv  = 1'b1;
         key_sdi = key[i];
         tick();
         if (ack0 || ack1) saw_ack = 1'b1;
      end
      key_sv  = 1'b0;
      key_sdi = 1'b0;
   endtask

   // Wait (bounded) for any ack; n = edges waited
   task automatic wait_ack(input int limit, output int n);
      n = 0;
      while (!(ack0 || ack1) && n < limit) begin
         tick();
         n++;
      end
   endtask

   initial begin
      bit saw;
      int n;
      int got;
      bit simul;
      logic [1:0]  ids  [4];
      logic [16:0] data [4];

      rst = 1'b1; key_start = 1'b0; key_sdi = 1'b0; key_sv = 1'b0;
      req0 = 1'b0; req1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      #1;
      chk("rst_keyinput", keyinput, 32'h0);
      chk("rst_key_ready", 32'(key_ready), 32'h0);
      chk("rst_acks", 32'({ack1, ack0}), 32'h0);
      chk("rst_rsp", 32'(rsp_data), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      tick(); tick();
      rst = 1'b0;

      // NOKEY: request must be ignored
      req0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222;
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ack0 || ack1) saw = 1'b1;
      end
      chk("nokey_no_ack", 32'(saw), 32'h0);
      chk("nokey_busy", 32'(busy), 32'h1);
      chk("nokey_add1", 32'(add1), 32'h0);
      req0 = 1'b0;

      // First key load with valid gaps
      key_start = 1'b1; tick(); key_start = 1'b0;
      load_bits(32'hB80CB450, 1'b1, 32'h0, saw);
      chk("load1_no_ack", 32'(saw), 32'h0);
      chk("load1_keyinput", keyinput, 32'hB80CB450);
      chk("load1_key_ready", 32'(key_ready), 32'h1);
      chk("load1_idle_busy", 32'(busy), 32'h0);

      // Single req0 transaction, latency and result
      a0 = 16'h29AF; b0 = 16'h7A1B; req0 = 1'b1;
      tick();
      chk("t0_busy", 32'(busy), 32'h1);
      wait_ack(20, n);
      chk("t0_latency", 32'(n), 32'd4);
      chk("t0_acks", 32'({ack1, ack0}), 32'h1);
      chk("t0_rsp", 32'(rsp_data), 32'h0A3CA);
      req0 = 1'b0;
      tick();
      chk("t0_ack_pulse", 32'({ack1, ack0}), 32'h0);
      chk("t0_add_hold", 32'({add1, add2}), 32'h29AF7A1B);

      // Lone req1 transaction, moves the pointer back to req0
      a1 = 16'h1234; b1 = 16'h0001; req1 = 1'b1;
      tick();
      wait_ack(20, n);
      chk("t1_latency", 32'(n), 32'd4);
      chk("t1_acks", 32'({ack1, ack0}), 32'h2);
      chk("t1_rsp", 32'(rsp_data), 32'h01235);
      req1 = 1'b0;

      // Contention: both held, expect 0,1,0,1
      a0 = 16'h8943; b0 = 16'hFFFF; a1 = 16'h5555; b1 = 16'hAAAA;
      req0 = 1'b1; req1 = 1'b1;
      got = 0; simul = 1'b0;
      for (int i = 0; i < 60 && got < 4; i++) begin
         tick();
         if (ack0 && ack1) simul = 1'b1;
         if (ack0 || ack1) begin
            ids[got]  = {ack1, ack0};
            data[got] = rsp_data;
            got++;
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("rr_count", 32'(got), 32'd4);
      chk("rr_simul", 32'(simul), 32'h0);
      for (int i = 0; i < got; i++) begin
         chk("rr_id", 32'(ids[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
         chk("rr_rsp", 32'(data[i]), (i % 2 == 0) ? 32'h18942 : 32'h0FFFF);
      end
      tick();

`ifndef SCHED_KEY_LOCK_EN
      // Re-key from IDLE takes priority over a pending req1
      a1 = 16'h00FF; b1 = 16'h0001; req1 = 1'b1; key_start = 1'b1;
      tick();
      key_start = 1'b0;
      chk("rekey_ready_drop", 32'(key_ready), 32'h0);
      chk("rekey_key_kept", keyinput, 32'hB80CB450);
      load_bits(32'h13579BDF, 1'b0, 32'hB80CB450, saw);
      chk("rekey_no_ack", 32'(saw), 32'h0);
      chk("rekey_keyinput", keyinput, 32'h13579BDF);
      chk("rekey_ready", 32'(key_ready), 32'h1);
      wait_ack(20, n);
      chk("rekey_ack_latency", 32'(n), 32'd5);
      chk("rekey_acks", 32'({ack1, ack0}), 32'h2);
      chk("rekey_rsp", 32'(rsp_data), 32'h00100);
      req1 = 1'b0;
`else
      // Locked: re-key attempt is ignored and flagged, request proceeds
      a1 = 16'h00FF; b1 = 16'h0001; req1 = 1'b1; key_start = 1'b1;
      tick();
      key_start = 1'b0;
      chk("lock_err_pulse", 32'(key_err), 32'h1);
      chk("lock_key_ready", 32'(key_ready), 32'h1);
      tick();
      chk("lock_err_clear", 32'(key_err), 32'h0);
      wait_ack(20, n);
      chk("lock_ack_latency", 32'(n), 32'd3);
      chk("lock_acks", 32'({ack1, ack0}), 32'h2);
      chk("lock_rsp", 32'(rsp_data), 32'h00100);
      chk("lock_keyinput", keyinput, 32'hB80CB450);
      req1 = 1'b0;
`endif
      tick();

      // Reset in the middle of SETTLE
      a0 = 16'h0001; b0 = 16'h0002; req0 = 1'b1;
      tick(); tick(); tick();
      chk("mid_add1", 32'(add1), 32'h0001);
      #2 rst = 1'b1;
      #1;
      chk("arst_keyinput", keyinput, 32'h0);
      chk("arst_key_ready", 32'(key_ready), 32'h0);
      chk("arst_ops", 32'({add1, add2}), 32'h0);
      chk("arst_rsp", 32'(rsp_data), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      tick(); tick();
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack0 || ack1) saw = 1'b1;
      end
      chk("post_rst_no_ack", 32'(saw), 32'h0);
      chk("post_rst_nokey_busy", 32'(busy), 32'h1);
      req0 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
